// File: rtl/memory_access.sv
// MEM stage of the pipeline: performs data-memory or semaphore bus
// accesses for the instruction in EX, then commits writeback and redirect.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   suspend_cpu               stall; blocks acceptance and commit
//   phase_done                EX inputs consumed on this edge
//   ex_*                      operands/control from the EX stage
//   dmem_*                    data memory request/ack bus
//   sema_*                    semaphore request/ack bus
//   mem_valid, mem_rd_id,
//   mem_reg_write, mem_wb_data  registered writeback bundle
//   pc_redirect, pc_target    registered branch redirect to fetch
//   mem_fault                 one-cycle pulse: illegal control or timeout
module memory_access #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        suspend_cpu,
    output logic        phase_done,

    input  logic        ex_valid,
    input  logic [15:0] ex_alu_result,
    input  logic [3:0]  ex_rd_id,
    input  logic [7:0]  ex_mem_addr,
    input  logic [15:0] ex_mem_write_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_sema_read,
    input  logic        ex_sema_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_mem_branch,
    input  logic        ex_branch_taken,
    input  logic [7:0]  ex_branch_target,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,

    output logic        sema_req,
    output logic        sema_we,
    output logic [7:0]  sema_addr,
    output logic [15:0] sema_wdata,
    input  logic [15:0] sema_rdata,
    input  logic        sema_ack,

    output logic        mem_valid,
    output logic [3:0]  mem_rd_id,
    output logic        mem_reg_write,
    output logic [15:0] mem_wb_data,

    output logic        pc_redirect,
    output logic [7:0]  pc_target,

    output logic        mem_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DMEM = 2'd1;
    localparam logic [1:0] S_SEMA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] TO_LIM = 4'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        nowb_q, nowb_d;

    logic        dreq_q, dreq_d;
    logic        dwe_q, dwe_d;
    logic [7:0]  daddr_q, daddr_d;
    logic [15:0] dwdata_q, dwdata_d;

    logic        sreq_q, sreq_d;
    logic        swe_q, swe_d;
    logic [7:0]  saddr_q, saddr_d;
    logic [15:0] swdata_q, swdata_d;

    logic        valid_q, valid_d;
    logic [3:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic [15:0] wb_q, wb_d;
    logic        redir_q, redir_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        fault_q, fault_d;

    logic        any_mem;
    logic        any_sema;
    logic        illegal;
    logic        go;
    logic        commit;
    logic        force0;
    logic [3:0]  cnt_inc;

    assign any_mem  = ex_mem_read | ex_mem_write;
    assign any_sema = ex_sema_read | ex_sema_write;
    assign illegal  = any_mem & any_sema;
    assign go       = ex_valid & ~suspend_cpu;
    assign cnt_inc  = cnt_q + 4'd1;

    // In IDLE only a legal bus access holds the EX inputs; an illegal
    // mix of flags completes immediately like a plain ALU op.
    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            S_IDLE: phase_done = ~ex_valid |
                                 (~suspend_cpu & ~(any_mem ^ any_sema));
            S_DONE: phase_done = 1'b1;
            default: phase_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        nowb_d   = nowb_q;
        dreq_d   = dreq_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        sreq_d   = sreq_q;
        swe_d    = swe_q;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;
        valid_d  = 1'b0;
        rd_d     = rd_q;
        rw_d     = rw_q;
        wb_d     = wb_q;
        redir_d  = 1'b0;
        tgt_d    = tgt_q;
        fault_d  = 1'b0;
        commit   = 1'b0;
        force0   = nowb_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (illegal) begin
                        commit  = 1'b1;
                        force0  = 1'b1;
                        fault_d = 1'b1;
                    end else if (any_mem) begin
                        // read+write together degrades to a write
                        dreq_d   = 1'b1;
                        dwe_d    = ex_mem_write;
                        daddr_d  = ex_mem_addr;
                        dwdata_d = ex_mem_write_data;
                        cnt_d    = 4'd0;
                        nowb_d   = 1'b0;
                        state_d  = S_DMEM;
                    end else if (any_sema) begin
                        sreq_d   = 1'b1;
                        swe_d    = ex_sema_write;
                        saddr_d  = ex_mem_addr;
                        swdata_d = ex_mem_write_data;
                        cnt_d    = 4'd0;
                        nowb_d   = 1'b0;
                        state_d  = S_SEMA;
                    end else begin
                        commit = 1'b1;
                        force0 = 1'b0;
                    end
                end
            end

            S_DMEM: begin
                if (dmem_ack) begin
                    dreq_d  = 1'b0;
                    rdata_d = dmem_rdata;
                    state_d = S_DONE;
                end else if (cnt_inc == TO_LIM) begin
                    dreq_d  = 1'b0;
                    rdata_d = 16'h0000;
                    nowb_d  = 1'b1;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_SEMA: begin
                if (sema_ack) begin
                    sreq_d  = 1'b0;
                    rdata_d = sema_rdata;
                    state_d = S_DONE;
                end else if (cnt_inc == TO_LIM) begin
                    sreq_d  = 1'b0;
                    rdata_d = 16'h0000;
                    nowb_d  = 1'b1;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DONE: begin
                if (!suspend_cpu) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // EX inputs are held stable until phase_done, so the commit
        // reads them directly instead of keeping private copies.
        if (commit) begin
            valid_d = 1'b1;
            rd_d    = ex_rd_id;
            rw_d    = ex_reg_write & ~force0;
            wb_d    = ex_mem_to_reg ? rdata_q : ex_alu_result;
            redir_d = ex_mem_branch & ex_branch_taken;
            tgt_d   = ex_branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= 16'h0000;
            nowb_q   <= 1'b0;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= 8'h00;
            dwdata_q <= 16'h0000;
            sreq_q   <= 1'b0;
            swe_q    <= 1'b0;
            saddr_q  <= 8'h00;
            swdata_q <= 16'h0000;
            valid_q  <= 1'b0;
            rd_q     <= 4'd0;
            rw_q     <= 1'b0;
            wb_q     <= 16'h0000;
            redir_q  <= 1'b0;
            tgt_q    <= 8'h00;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            nowb_q   <= nowb_d;
            dreq_q   <= dreq_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            sreq_q   <= sreq_d;
            swe_q    <= swe_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            wb_q     <= wb_d;
            redir_q  <= redir_d;
            tgt_q    <= tgt_d;
            fault_q  <= fault_d;
        end
    end

    assign dmem_req      = dreq_q;
    assign dmem_we       = dwe_q;
    assign dmem_addr     = daddr_q;
    assign dmem_wdata    = dwdata_q;
    assign sema_req      = sreq_q;
    assign sema_we       = swe_q;
    assign sema_addr     = saddr_q;
    assign sema_wdata    = swdata_q;
    assign mem_valid     = valid_q;
    assign mem_rd_id     = rd_q;
    assign mem_reg_write = rw_q;
    assign mem_wb_data   = wb_q;
    assign pc_redirect   = redir_q;
    assign pc_target     = tgt_q;
    assign mem_fault     = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: scoreboard of expected writebacks,
// bus responder with programmable ack delay, timeout and reset cases.
module tb_memory_access;

    localparam int TO = 15;

    localparam logic [7:0] C_MR  = 8'h80;
    localparam logic [7:0] C_MW  = 8'h40;
    localparam logic [7:0] C_SR  = 8'h20;
    localparam logic [7:0] C_SW  = 8'h10;
    localparam logic [7:0] C_RW  = 8'h08;
    localparam logic [7:0] C_M2R = 8'h04;
    localparam logic [7:0] C_BR  = 8'h02;
    localparam logic [7:0] C_TK  = 8'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        suspend_cpu;
    logic        phase_done;
    logic        ex_valid;
    logic [15:0] ex_alu_result;
    logic [3:0]  ex_rd_id;
    logic [7:0]  ex_mem_addr;
    logic [15:0] ex_mem_write_data;
    logic        ex_mem_read, ex_mem_write;
    logic        ex_sema_read, ex_sema_write;
    logic        ex_reg_write, ex_mem_to_reg;
    logic        ex_mem_branch, ex_branch_taken;
    logic [7:0]  ex_branch_target;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic        sema_req, sema_we, sema_ack;
    logic [7:0]  sema_addr;
    logic [15:0] sema_wdata, sema_rdata;
    logic        mem_valid, mem_reg_write;
    logic [3:0]  mem_rd_id;
    logic [15:0] mem_wb_data;
    logic        pc_redirect;
    logic [7:0]  pc_target;
    logic        mem_fault;

    memory_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .suspend_cpu(suspend_cpu),
        .phase_done(phase_done), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_rd_id(ex_rd_id),
        .ex_mem_addr(ex_mem_addr),
        .ex_mem_write_data(ex_mem_write_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_sema_read(ex_sema_read), .ex_sema_write(ex_sema_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_branch(ex_mem_branch),
        .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .sema_req(sema_req), .sema_we(sema_we),
        .sema_addr(sema_addr), .sema_wdata(sema_wdata),
        .sema_rdata(sema_rdata), .sema_ack(sema_ack),
        .mem_valid(mem_valid), .mem_rd_id(mem_rd_id),
        .mem_reg_write(mem_reg_write), .mem_wb_data(mem_wb_data),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .mem_fault(mem_fault)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic        rw;
        logic [15:0] wb;
        logic        redir;
        logic [7:0]  tgt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pop one expected writeback per mem_valid pulse.
    always @(negedge clk) begin
        if (rstn && mem_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_rd", 32'(mem_rd_id), 32'(mon_e.rd));
                chk("sb_rw", 32'(mem_reg_write), 32'(mon_e.rw));
                chk("sb_wb", 32'(mem_wb_data), 32'(mon_e.wb));
                chk("sb_redir", 32'(pc_redirect), 32'(mon_e.redir));
                if (mon_e.redir)
                    chk("sb_tgt", 32'(pc_target), 32'(mon_e.tgt));
            end
        end
    end

    task automatic drive_ex(input logic [15:0] alu, input logic [3:0] rd,
                            input logic [7:0] addr,
                            input logic [15:0] wdata,
                            input logic [7:0] ctl, input logic [7:0] tgt);
        ex_alu_result     = alu;
        ex_rd_id          = rd;
        ex_mem_addr       = addr;
        ex_mem_write_data = wdata;
        ex_mem_read       = ctl[7];
        ex_mem_write      = ctl[6];
        ex_sema_read      = ctl[5];
        ex_sema_write     = ctl[4];
        ex_reg_write      = ctl[3];
        ex_mem_to_reg     = ctl[2];
        ex_mem_branch     = ctl[1];
        ex_branch_taken   = ctl[0];
        ex_branch_target  = tgt;
    endtask

    // ack_k: ack raised k cycles after req rises (<0: never).
    // susp: cycles of suspend_cpu held once the request has finished.
    task automatic run_op(input string tag, input logic [15:0] alu,
                          input logic [3:0] rd, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic [7:0] ctl,
                          input logic [7:0] tgt, input int ack_k,
                          input logic [15:0] rdata, input int susp);
        logic mem, sem, ill, acc, tmo, ack_now;
        int   exp_req, exp_lat, exp_flt;
        int   reqs, flts, lat, sleft;
        bit   sdone;
        exp_t x;
        mem     = ctl[7] | ctl[6];
        sem     = ctl[5] | ctl[4];
        ill     = mem & sem;
        acc     = (mem | sem) & ~ill;
        tmo     = acc & (ack_k < 0);
        exp_req = !acc ? 0 : (tmo ? TO : ack_k + 1);
        exp_lat = !acc ? 1 : ((tmo ? TO + 2 : ack_k + 3) + susp);
        exp_flt = (ill | tmo) ? 1 : 0;
        x.rd    = rd;
        x.rw    = ctl[3] & ~(ill | tmo);
        x.wb    = ctl[2] ? (tmo ? 16'h0000 : rdata) : alu;
        x.redir = ctl[1] & ctl[0];
        x.tgt   = tgt;
        reqs = 0; flts = 0; lat = -1; sleft = 0; sdone = 0;

        drive_ex(alu, rd, addr, wdata, ctl, tgt);
        dmem_rdata  = rdata;
        sema_rdata  = rdata;
        suspend_cpu = 1'b0;
        ex_valid    = 1'b1;
        sb.push_back(x);
        #1;
        chk({tag, "_pd_accept"}, 32'(phase_done), 32'(!acc));

        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (mem_fault) flts++;
            if (dmem_req || sema_req) begin
                reqs++;
                if (reqs == 1) begin
                    chk({tag, "_dreq"}, 32'(dmem_req), 32'(mem));
                    chk({tag, "_sreq"}, 32'(sema_req), 32'(sem));
                    if (mem) begin
                        chk({tag, "_dwe"}, 32'(dmem_we), 32'(ctl[6]));
                        chk({tag, "_daddr"}, 32'(dmem_addr), 32'(addr));
                        chk({tag, "_dwdata"}, 32'(dmem_wdata), 32'(wdata));
                    end else begin
                        chk({tag, "_swe"}, 32'(sema_we), 32'(ctl[4]));
                        chk({tag, "_saddr"}, 32'(sema_addr), 32'(addr));
                        chk({tag, "_swdata"}, 32'(sema_wdata), 32'(wdata));
                    end
                end
                chk({tag, "_pd_wait"}, 32'(phase_done), 32'd0);
                ack_now  = (ack_k >= 0) && (reqs == ack_k + 1);
                dmem_ack = mem & ack_now;
                sema_ack = sem & ack_now;
            end else begin
                dmem_ack = 1'b0;
                sema_ack = 1'b0;
                if (susp > 0 && reqs > 0 && !sdone) begin
                    suspend_cpu = 1'b1;
                    sleft = susp;
                    sdone = 1;
                end else if (sleft > 0) begin
                    chk({tag, "_susp_hold"}, 32'(mem_valid), 32'd0);
                    chk({tag, "_susp_pd"}, 32'(phase_done), 32'd1);
                    sleft--;
                    if (sleft == 0) suspend_cpu = 1'b0;
                end
            end
            if (mem_valid) begin
                lat = i;
                break;
            end
        end

        ex_valid    = 1'b0;
        dmem_ack    = 1'b0;
        sema_ack    = 1'b0;
        suspend_cpu = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_req_cycles"}, 32'(reqs), 32'(exp_req));
        chk({tag, "_faults"}, 32'(flts), 32'(exp_flt));

        @(posedge clk); #1;
        chk({tag, "_valid_pulse"}, 32'(mem_valid), 32'd0);
        chk({tag, "_redir_pulse"}, 32'(pc_redirect), 32'd0);
        chk({tag, "_fault_pulse"}, 32'(mem_fault), 32'd0);
        chk({tag, "_pd_idle"}, 32'(phase_done), 32'd1);
    endtask

    initial begin
        rstn        = 1'b0;
        suspend_cpu = 1'b0;
        ex_valid    = 1'b0;
        dmem_ack    = 1'b0;
        sema_ack    = 1'b0;
        dmem_rdata  = 16'h0000;
        sema_rdata  = 16'h0000;
        drive_ex(16'h0, 4'd0, 8'h0, 16'h0, 8'h00, 8'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dreq", 32'(dmem_req), 32'd0);
        chk("rst_sreq", 32'(sema_req), 32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_redir", 32'(pc_redirect), 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_daddr", 32'(dmem_addr), 32'd0);
        chk("rst_wb", 32'(mem_wb_data), 32'd0);
        chk("rst_pd", 32'(phase_done), 32'd1);
        rstn = 1'b1;
        @(posedge clk); #1;

        run_op("add", 16'h1234, 4'd3, 8'h00, 16'h0000, C_RW,
               8'h00, 0, 16'h0000, 0);
        run_op("load", 16'h0000, 4'd7, 8'h40, 16'h0000,
               C_MR | C_RW | C_M2R, 8'h00, 2, 16'hBEEF, 0);
        run_op("sema_wr", 16'h0077, 4'd5, 8'h05, 16'h0001, C_SW,
               8'h00, 1, 16'hAAAA, 3);

        // Stalled in IDLE: nothing accepted, inputs not consumed.
        drive_ex(16'h0, 4'd4, 8'h21, 16'h0, C_MR | C_RW | C_M2R, 8'h0);
        dmem_rdata  = 16'h0F0F;
        suspend_cpu = 1'b1;
        ex_valid    = 1'b1;
        #1;
        chk("isusp_pd", 32'(phase_done), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("isusp_valid", 32'(mem_valid), 32'd0);
            chk("isusp_dreq", 32'(dmem_req), 32'd0);
        end
        run_op("load_k0", 16'h0000, 4'd4, 8'h21, 16'h0000,
               C_MR | C_RW | C_M2R, 8'h00, 0, 16'h0F0F, 0);

        // Reset in the middle of a data-memory wait.
        drive_ex(16'h0, 4'd6, 8'h99, 16'h0, C_MR | C_RW, 8'h0);
        ex_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstw_pre_req", 32'(dmem_req), 32'd1);
        rstn     = 1'b0;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstw_dreq", 32'(dmem_req), 32'd0);
        chk("rstw_daddr", 32'(dmem_addr), 32'd0);
        chk("rstw_dwe", 32'(dmem_we), 32'd0);
        chk("rstw_sreq", 32'(sema_req), 32'd0);
        chk("rstw_valid", 32'(mem_valid), 32'd0);
        chk("rstw_fault", 32'(mem_fault), 32'd0);
        chk("rstw_redir", 32'(pc_redirect), 32'd0);
        chk("rstw_wb", 32'(mem_wb_data), 32'd0);
        chk("rstw_rd", 32'(mem_rd_id), 32'd0);
        chk("rstw_pd", 32'(phase_done), 32'd1);
        rstn = 1'b1;
        drive_ex(16'h0, 4'd0, 8'h0, 16'h0, 8'h00, 8'h0);
        @(posedge clk); #1;
        run_op("post_rst", 16'h00C3, 4'd8, 8'h00, 16'h0000, C_RW,
               8'h00, 0, 16'h0000, 0);

        run_op("timeout", 16'h1111, 4'd9, 8'h10, 16'h0000,
               C_MR | C_RW | C_M2R, 8'h00, -1, 16'hDEAD, 0);
        run_op("beq", 16'h0000, 4'd0, 8'h00, 16'h0000, C_BR | C_TK,
               8'h2A, 0, 16'h0000, 0);
        run_op("bne", 16'h0000, 4'd0, 8'h00, 16'h0000, C_BR,
               8'h55, 0, 16'h0000, 0);
        run_op("illegal", 16'h4321, 4'd2, 8'h33, 16'h0009,
               C_MR | C_SW | C_RW, 8'h00, 0, 16'h0000, 0);
        run_op("rdwr", 16'h00AA, 4'd1, 8'h80, 16'hCAFE,
               C_MR | C_MW | C_RW, 8'h00, 0, 16'h1357, 0);
        run_op("sema_rd", 16'h0000, 4'd12, 8'hF0, 16'h0000,
               C_SR | C_RW | C_M2R, 8'h00, 3, 16'h5A5A, 0);
        run_op("sema_tmo", 16'h2222, 4'd11, 8'h0C, 16'h0000,
               C_SR | C_RW | C_M2R, 8'h00, -1, 16'h7777, 0);

        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, max cycles waited for a bus ack before fault (range 1-15).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 suspend_cpu  in  1  stall; gates acceptance and result commit.
REQ-005 phase_done  out  1  high when the current EX inputs are consumed on this edge.
REQ-006 ex_valid  in  1  EX inputs carry an instruction.
REQ-007 ex_alu_result  in  16, ex_rd_id  in  4, ex_mem_addr  in  8, ex_mem_write_data  in  16: operands from EX.
REQ-008 ex_mem_read, ex_mem_write, ex_sema_read, ex_sema_write, ex_reg_write, ex_mem_to_reg, ex_mem_branch, ex_branch_taken  in  1 each: control from EX.
REQ-009 ex_branch_target  in  8  branch destination.
REQ-010 dmem_req  out  1, dmem_we  out  1, dmem_addr  out  8, dmem_wdata  out  16, dmem_rdata  in  16, dmem_ack  in  1: data memory bus.
REQ-011 sema_req  out  1, sema_we  out  1, sema_addr  out  8, sema_wdata  out  16, sema_rdata  in  16, sema_ack  in  1: semaphore bus.
REQ-012 mem_valid  out  1, mem_rd_id  out  4, mem_reg_write  out  1, mem_wb_data  out  16: writeback outputs, registered.
REQ-013 pc_redirect  out  1, pc_target  out  8: registered branch redirect to fetch.
REQ-014 mem_fault  out  1  one-cycle pulse on illegal control or bus timeout.

Function
REQ-015 FSM states IDLE, DMEM_WAIT, SEMA_WAIT, DONE; reset state IDLE.
REQ-016 IDLE, ex_valid=1, suspend_cpu=0, no mem/sema flag: phase_done=1 combinationally; next edge loads writeback/redirect registers, mem_valid=1 for one cycle.
REQ-017 IDLE, ex_valid=1, suspend_cpu=0, ex_mem_read or ex_mem_write only: phase_done=0; next state DMEM_WAIT; dmem_req=1, dmem_we=ex_mem_write, dmem_addr=ex_mem_addr, dmem_wdata=ex_mem_write_data registered.
REQ-018 Same with ex_sema_read or ex_sema_write only: next state SEMA_WAIT, sema_* driven analogously.
REQ-019 ex_mem_read and ex_mem_write both set: write performed only (same for sema pair).
REQ-020 Any mem flag together with any sema flag: no bus access, mem_fault pulse, completes as REQ-016 with mem_reg_write forced 0.
REQ-021 DMEM_WAIT/SEMA_WAIT: req and address/data held stable until ack; phase_done=0; suspend_cpu does not affect waiting.
REQ-022 On ack edge: req drops next cycle, read data (dmem_rdata or sema_rdata) latched, next state DONE.
REQ-023 Wait counter (4-bit) counts cycles in a WAIT state; reaching TIMEOUT_CYCLES without ack: req drops, mem_fault pulse, load data=0, mem_reg_write forced 0, next state DONE.
REQ-024 DONE: phase_done=1; if suspend_cpu=0, next edge commits writeback/redirect registers, mem_valid pulse, state IDLE; else hold DONE.
REQ-025 mem_wb_data = ex_mem_to_reg ? latched read data : ex_alu_result; mem_rd_id=ex_rd_id; mem_reg_write=ex_reg_write unless forced 0.
REQ-026 pc_redirect = ex_mem_branch & ex_branch_taken, pulsed with mem_valid; pc_target=ex_branch_target.
REQ-027 Latency: non-memory op 1 cycle; memory op with ack k cycles after req rises: mem_valid at k+3 edges after acceptance edge (no suspend).
REQ-028 ex_valid=0 or suspend_cpu=1 in IDLE: no state change, mem_valid=0, pc_redirect=0, phase_done=1 only if ex_valid=0.
REQ-029 Upstream holds all ex_* inputs stable while phase_done=0.

Reset
REQ-030 rstn=0 at an edge: state IDLE, counter 0, all outputs 0 (dmem_req, sema_req, mem_valid, pc_redirect, mem_fault, data/address buses), including mid-wait; pending access abandoned.

Verification
REQ-031 ADD result 0x1234, rd=3, reg_write=1 -> next cycle mem_valid=1, mem_wb_data=0x1234, mem_rd_id=3, phase_done=1 throughout.
REQ-032 Load addr 0x40, ack after 2 cycles with rdata 0xBEEF, mem_to_reg=1 -> dmem_req high exactly 3 cycles, dmem_we=0, mem_wb_data=0xBEEF, mem_valid on edge 5.
REQ-033 Sema write addr 0x05, data 0x0001, suspend_cpu=1 during DONE for 3 cycles -> sema_we=1, result held, mem_valid only after suspend drops.
REQ-034 Load with no ack -> dmem_req drops after 15 cycles, mem_fault one pulse, mem_reg_write=0.
REQ-035 rstn=0 during DMEM_WAIT -> next cycle dmem_req=0, state IDLE, all outputs 0.
REQ-036 BEQ taken, target 0x2A -> pc_redirect one-cycle pulse, pc_target=0x2A; mem+sema flags both set -> mem_fault, no req.
